systolic_drain: RTL and testbench

- Output-side collector for the 4x4 weight-stationary systolic array.
- Column results leave the array's bottom edge skewed: column c of a vector arrives c cycles after column 0. This block removes the skew and buffers the aligned 4-word result vectors in a FIFO.
- It presents the vectors to downstream logic over a valid/ready handshake, and tells the feeder to stall before the buffer can overflow.

---
 rtl/systolic_drain.sv | 108 ++++++++++
 tb/tb_systolic_drain.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_drain.sv
// Output-side collector for the weight-stationary systolic array: removes the
// per-column skew and buffers aligned result vectors in a show-ahead FIFO.
module systolic_drain #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [N-1:0][DATA_W-1:0]     col_in,
  output logic                         stall_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0][DATA_W-1:0]     out_data,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         ovf,
  input  logic                         clear_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 2;

  logic [N-2:0]                vpipe_q;
  logic [N-1:0][DATA_W-1:0]    aligned;
  logic [N-1:0][DATA_W-1:0]    mem_q [DEPTH];
  logic [AW:0]                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                        out_valid_q, out_valid_d;
  logic [N-1:0][DATA_W-1:0]    out_data_q, out_data_d;
  logic                        ovf_q, ovf_d;
  logic                        wr, full, pop, push, drop;
  logic [LW-1:0]               inflight, level;

  // Column c arrives c cycles late, so it needs N-1-c stages to line up.
  for (genvar c = 0; c < N - 1; c++) begin : g_skew
    logic [DATA_W-1:0] sh_q [N-1-c];
    always_ff @(posedge clk) begin
      sh_q[0] <= col_in[c];
      for (int k = 1; k < N - 1 - c; k++) sh_q[k] <= sh_q[k-1];
    end
    assign aligned[c] = sh_q[N-2-c];
  end
  assign aligned[N-1] = col_in[N-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q[0] <= in_valid;
      for (int i = 1; i < N - 1; i++) vpipe_q[i] <= vpipe_q[i-1];
    end
  end

  assign wr    = vpipe_q[N-2];
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = out_valid_q && out_ready;
  assign push  = wr && (!full || pop);
  assign drop  = wr && full && !pop;

  // The head register is loaded from the post-edge head; a push into an
  // otherwise-empty FIFO is forwarded straight from the deskew outputs.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    out_valid_d = (wr_ptr_d != rd_ptr_d);
    if (push && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
      out_data_d = aligned;
    else
      out_data_d = mem_q[rd_ptr_d[AW-1:0]];
    ovf_d = ovf_q;
    if (clear_ovf) ovf_d = 1'b0;
    if (drop)      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= aligned;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ovf_q       <= ovf_d;
    end
  end

  // Vectors still in the valid pipeline will land in the FIFO regardless.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < N - 1; i++) inflight = inflight + LW'(vpipe_q[i]);
    level     = LW'(count) + inflight;
    stall_req = (level >= LW'(DEPTH - 1));
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Randomized and directed bench for systolic_drain, checked against a
// queue-based model of issued, in-flight and stored vectors.
module tb_systolic_drain;

  localparam int N      = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  typedef logic [N-1:0][DATA_W-1:0] vec_t;

  logic                  clk;
  logic                  reset;
  logic                  inValid;
  vec_t                  colIn;
  logic                  stallReq;
  logic                  outValid;
  logic                  outReady;
  vec_t                  outData;
  logic [$clog2(DEPTH):0] count;
  logic                  ovf;
  logic                  clearOvf;

  systolic_drain #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (inValid),
    .col_in    (colIn),
    .stall_req (stallReq),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .count     (count),
    .ovf       (ovf),
    .clear_ovf (clearOvf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checkCount = 0;
  int   errorCount = 0;
  vec_t mQueue[$];
  bit   hv [N];
  vec_t hd [N];
  bit   mOvf;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Vectors in the valid pipeline right now are those issued in the last N-1 cycles.
  function automatic bit modelStall();
    int level = mQueue.size();
    for (int k = 0; k < N - 1; k++) level += int'(hv[k]);
    return level >= DEPTH - 1;
  endfunction

  function automatic vec_t makeVec(input logic [31:0] base);
    vec_t v;
    for (int c = 0; c < N; c++) v[c] = base + c;
    return v;
  endfunction

  function automatic vec_t randVec();
    vec_t v;
    for (int c = 0; c < N; c++) v[c] = $urandom;
    return v;
  endfunction

  task automatic modelReset();
    mQueue.delete();
    for (int k = 0; k < N; k++) hv[k] = 1'b0;
    mOvf = 1'b0;
  endtask

  task automatic checkAll();
    checkOutput("outValid", 32'(outValid), 32'(mQueue.size() != 0));
    checkOutput("count", 32'(count), 32'(mQueue.size()));
    checkOutput("stall", 32'(stallReq), 32'(modelStall()));
    checkOutput("ovf", 32'(ovf), 32'(mOvf));
    if (mQueue.size() != 0)
      for (int c = 0; c < N; c++)
        checkOutput($sformatf("data%0d", c), outData[c], mQueue[0][c]);
  endtask

  // One clock cycle: drive skewed inputs, let the edge happen, advance the model, check.
  task automatic applyStimulus(input bit inV, input vec_t vec, input bit rdy, input bit clr);
    bit popNow;
    for (int k = N - 1; k > 0; k--) begin
      hv[k] = hv[k-1];
      hd[k] = hd[k-1];
    end
    hv[0] = inV;
    hd[0] = vec;
    inValid  = inV;
    outReady = rdy;
    clearOvf = clr;
    for (int c = 0; c < N; c++) colIn[c] = hv[c] ? hd[c][c] : $urandom;
    @(posedge clk);
    #1;
    popNow = (mQueue.size() != 0) && rdy;
    if (popNow) void'(mQueue.pop_front());
    if (hv[N-1]) begin
      if (mQueue.size() == DEPTH) mOvf = 1'b1;
      else mQueue.push_back(hd[N-1]);
    end
    if (clr && !(hv[N-1] && mQueue.size() == DEPTH && !popNow)) begin
      if (!(hv[N-1] && !popNow && mQueue.size() == DEPTH)) mOvf = 1'b0;
    end
    checkAll();
  endtask

  task automatic idle(input int cycles, input bit rdy);
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, randVec(), rdy, 1'b0);
  endtask

  task automatic fillEight(input logic [31:0] base);
    for (int k = 0; k < DEPTH; k++) applyStimulus(1'b1, makeVec(base + k * 32'h100), 1'b0, 1'b0);
    idle(N, 1'b0);
  endtask

  initial begin
    bit inV, rdy, clr;
    reset    = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    clearOvf = 1'b0;
    colIn    = '0;
    modelReset();
    #2;
    checkAll();
    checkOutput("rstData", outData[0], 32'h0);
    #1 reset = 1'b0;

    $display("[TB] single vector");
    applyStimulus(1'b1, makeVec(32'h10), 1'b1, 1'b0);
    idle(6, 1'b1);

    $display("[TB] burst of eight then drain");
    fillEight(32'h0);
    idle(3, 1'b0);
    idle(12, 1'b1);

    $display("[TB] overflow and clear");
    fillEight(32'h1000);
    applyStimulus(1'b1, makeVec(32'hDEAD0000), 1'b0, 1'b0);
    idle(N + 1, 1'b0);
    applyStimulus(1'b0, randVec(), 1'b0, 1'b1);
    idle(2, 1'b0);
    idle(12, 1'b1);

    $display("[TB] full with push and pop together");
    fillEight(32'h2000);
    applyStimulus(1'b1, makeVec(32'h2800), 1'b0, 1'b0);
    idle(N - 2, 1'b0);
    applyStimulus(1'b0, randVec(), 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(12, 1'b1);

    $display("[TB] ready toggling");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, makeVec(32'h3000 + k * 32'h100), 1'b0, 1'b0);
    idle(N, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, randVec(), 1'(i % 2 == 0), 1'b0);

    $display("[TB] async reset mid-operation");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, makeVec(32'h4000 + k * 32'h100), 1'b0, 1'b0);
    idle(N, 1'b0);
    applyStimulus(1'b1, makeVec(32'h4800), 1'b0, 1'b0);
    applyStimulus(1'b1, makeVec(32'h4900), 1'b0, 1'b0);
    inValid = 1'b0;
    #1 reset = 1'b1;
    #1;
    modelReset();
    checkAll();
    #1 reset = 1'b0;
    applyStimulus(1'b1, makeVec(32'h5000), 1'b1, 1'b0);
    idle(6, 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      inV = ($urandom_range(0, 3) != 0) && (!modelStall() || $urandom_range(0, 11) == 0);
      rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      applyStimulus(inV, randVec(), rdy, clr);
    end
    idle(12, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
